difftest_csr_snapshot: RTL and testbench

DIFFTEST_CSR_SNAPSHOT -- requirements
Module: difftest_csr_snapshot

---
 rtl/difftest_csr_snapshot.sv | 116 +++++++++++
 tb/tb_difftest_csr_snapshot.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_csr_snapshot.sv
// Captures committed CSR snapshots into a small FIFO. Each entry holds the CSR values,
// a per-CSR changed mask against the last accepted snapshot, and a sequence number.
module difftest_csr_snapshot #(
    parameter int XLEN    = 64,
    parameter int NUM_CSR = 18,
    parameter int DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        commit_valid,
    input  logic [NUM_CSR*XLEN-1:0]     csr_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CSR*XLEN-1:0]     out_csr_vec,
    output logic [NUM_CSR-1:0]          out_chg_mask,
    output logic [15:0]                 out_seq,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow,
    input  logic                        clr_overflow
);

    localparam int VW = NUM_CSR * XLEN;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [VW-1:0]      vec_mem  [DEPTH];
    logic [NUM_CSR-1:0] mask_mem [DEPTH];
    logic [15:0]        seq_mem  [DEPTH];

    logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               overflow_reg, overflow_next;
    logic [15:0]        seq_reg, seq_next;
    logic [VW-1:0]      prev_reg, prev_next;
    logic [NUM_CSR-1:0] chg_mask;
    logic               full, pop, push, drop;

    // Changed flag per CSR slot, relative to the last snapshot that was actually stored.
    for (genvar gi = 0; gi < NUM_CSR; gi++) begin : g_chg
        assign chg_mask[gi] = csr_vec[gi*XLEN +: XLEN] != prev_reg[gi*XLEN +: XLEN];
    end

    assign full      = count_reg == FULL_COUNT;
    assign out_valid = count_reg != '0;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign push      = commit_valid && (!full || pop);
    assign drop      = commit_valid && full && !pop;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        seq_next      = seq_reg;
        prev_next     = prev_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
            prev_next   = csr_vec;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        // Every commit consumes a sequence number, so dropped snapshots leave a visible gap.
        if (commit_valid) begin
            seq_next = seq_reg + 16'd1;
        end
        if (clr_overflow) begin
            overflow_next = 1'b0;
        end
        if (drop) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            seq_reg      <= '0;
            prev_reg     <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            seq_reg      <= seq_next;
            prev_reg     <= prev_next;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clock) begin
        if (push) begin
            vec_mem[wr_ptr_reg]  <= csr_vec;
            mask_mem[wr_ptr_reg] <= chg_mask;
            seq_mem[wr_ptr_reg]  <= seq_reg;
        end
    end

    assign out_csr_vec  = vec_mem[rd_ptr_reg];
    assign out_chg_mask = mask_mem[rd_ptr_reg];
    assign out_seq      = seq_mem[rd_ptr_reg];
    assign count        = count_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_difftest_csr_snapshot.sv
// Scoreboard bench for difftest_csr_snapshot: expected snapshots are queued at commit
// time and compared against the FIFO head when the consumer pops it.
module tb_difftest_csr_snapshot;

    localparam int XLEN    = 64;
    localparam int NUM_CSR = 18;
    localparam int DEPTH   = 4;
    localparam int W       = NUM_CSR * XLEN;
    localparam int CW      = $clog2(DEPTH + 1);

    typedef struct {
        logic [W-1:0]       vec;
        logic [NUM_CSR-1:0] mask;
        logic [15:0]        seq;
    } snap_t;

    logic               clock = 1'b0;
    logic               reset;
    logic               commit_valid;
    logic [W-1:0]       csr_vec;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_csr_vec;
    logic [NUM_CSR-1:0] out_chg_mask;
    logic [15:0]        out_seq;
    logic [CW-1:0]      count;
    logic               overflow;
    logic               clr_overflow;

    difftest_csr_snapshot #(.XLEN(XLEN), .NUM_CSR(NUM_CSR), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .csr_vec      (csr_vec),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_csr_vec  (out_csr_vec),
        .out_chg_mask (out_chg_mask),
        .out_seq      (out_seq),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_errors = 0;
    snap_t        sb_q[$];
    logic [15:0]  m_seq;
    logic [W-1:0] m_prev;
    logic         m_ovf;
    bit           quiet = 0;
    bit           have_last = 0;
    logic [15:0]  last_seq;
    bit           wrap_seen = 0;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NUM_CSR-1:0] calc_mask(input logic [W-1:0] v, input logic [W-1:0] p);
        logic [NUM_CSR-1:0] m;
        for (int i = 0; i < NUM_CSR; i++) begin
            m[i] = v[i*XLEN +: XLEN] != p[i*XLEN +: XLEN];
        end
        return m;
    endfunction

    function automatic void model_reset();
        sb_q.delete();
        m_seq  = 16'd0;
        m_prev = '0;
        m_ovf  = 1'b0;
    endfunction

    // One clock cycle: drive, compare head mid-cycle, advance model, step past the edge.
    task automatic cycle(input logic cv, input logic [W-1:0] vec, input logic rdy, input logic clr);
        int    sz;
        bit    popped;
        bit    full;
        snap_t head;
        snap_t ent;
        commit_valid = cv;
        csr_vec      = vec;
        out_ready    = rdy;
        clr_overflow = clr;
        @(negedge clock);
        sz = sb_q.size();
        check("out_valid", W'(out_valid), W'(sz > 0));
        check("count", W'(count), W'(sz));
        check("overflow", W'(overflow), W'(m_ovf));
        popped = 0;
        if (sz > 0) begin
            head = sb_q[0];
            check("head_seq", W'(out_seq), W'(head.seq));
            check("head_mask", W'(out_chg_mask), W'(head.mask));
            check("head_vec", out_csr_vec, head.vec);
            if (rdy) begin
                void'(sb_q.pop_front());
                popped = 1;
                if (!quiet) $display("pop  seq=%04h mask=%05h", head.seq, head.mask);
                if (have_last && last_seq == 16'hFFFF && head.seq == 16'h0000) wrap_seen = 1;
                last_seq  = head.seq;
                have_last = 1;
            end
        end
        full = (sz == DEPTH);
        if (cv) begin
            if (!full || popped) begin
                ent.vec  = vec;
                ent.mask = calc_mask(vec, m_prev);
                ent.seq  = m_seq;
                sb_q.push_back(ent);
                m_prev = vec;
                if (!quiet) $display("push seq=%04h mask=%05h", ent.seq, ent.mask);
            end else begin
                if (!quiet) $display("drop seq=%04h", m_seq);
            end
            m_seq = m_seq + 16'd1;
        end
        if (clr) m_ovf = 1'b0;
        if (cv && full && !popped) m_ovf = 1'b1;
        @(posedge clock);
        #1;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
    endtask

    // Reset pulse strictly between clock edges; outputs must clear before the next edge.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_ovf", W'(overflow), W'(0));
        $display("reset asserted mid-cycle");
        #2 reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    logic [W-1:0] v_a;
    logic [W-1:0] v_b;
    logic [W-1:0] v_r;

    initial begin
        reset        = 1'b1;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        csr_vec      = '0;
        model_reset();
        @(posedge clock);
        #1;
        check("init_valid", W'(out_valid), W'(0));
        check("init_count", W'(count), W'(0));
        check("init_ovf", W'(overflow), W'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        // First commit: mstatus in slot 1 changes against zeroed prev.
        v_a = '0;
        v_a[1*XLEN +: XLEN] = 64'hA_0000_0000;
        cycle(1, v_a, 0, 0);
        check("first_valid", W'(out_valid), W'(1));
        check("first_seq", W'(out_seq), W'(16'd0));
        check("first_mask", W'(out_chg_mask), W'(18'h00002));
        check("first_count", W'(count), W'(1));
        cycle(0, '0, 1, 0);

        // Fill from fresh reset, then overflow.
        mid_reset();
        v_b = '0;
        v_b[3*XLEN +: XLEN] = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 4; i++) cycle(1, v_b, 0, 0);
        cycle(1, v_b, 0, 0);
        check("full_count", W'(count), W'(4));
        check("full_ovf", W'(overflow), W'(1));
        check("full_head_seq", W'(out_seq), W'(16'd0));
        cycle(0, '0, 1, 0);
        cycle(1, v_b, 0, 0);
        check("after_drop_seq", W'(sb_q[$].seq), W'(16'd5));
        check("after_drop_mask", W'(sb_q[$].mask), W'(0));

        // Full FIFO: simultaneous commit and pop is accepted.
        v_r = v_b;
        v_r[0 +: XLEN] = 64'd3;
        cycle(1, v_r, 1, 0);
        check("pp_count", W'(count), W'(4));
        check("pp_ovf", W'(overflow), W'(1));

        // Drop and clear together leaves overflow set; clear alone then clears it.
        cycle(1, v_r, 0, 1);
        check("clr_drop_ovf", W'(overflow), W'(1));
        cycle(0, v_r, 0, 1);
        check("clr_ovf", W'(overflow), W'(0));
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, '0, 1, 0);

        // Long streaming run through the sequence-number wrap.
        quiet = 1;
        v_r = '0;
        for (int i = 0; i < 65536; i++) begin
            v_r[(i % NUM_CSR)*XLEN +: XLEN] = {$urandom, $urandom};
            cycle(1, v_r, 1, 0);
        end
        cycle(0, '0, 1, 0);
        quiet = 0;
        check("seq_wrap_seen", W'(wrap_seen), W'(1));

        // Async reset with three entries stored.
        for (int i = 0; i < 3; i++) begin
            v_r[0 +: XLEN] = 64'(i + 7);
            cycle(1, v_r, 0, 0);
        end
        check("pre_rst_count", W'(count), W'(3));
        mid_reset();
        v_a = '0;
        v_a[5*XLEN +: XLEN] = 64'hFF;
        cycle(1, v_a, 0, 0);
        check("post_rst_seq", W'(out_seq), W'(16'd0));
        check("post_rst_mask", W'(out_chg_mask), W'(18'h00020));
        cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
